// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for bcd_countdown_timer.
//
// Macro: none (the AUTO_RELOAD_EN option lives in the timer module).
// Parameter: NUM_PAIRS - number of base-60 digit pairs; W = 8*NUM_PAIRS.
//
// Signals
//   start      1  start / pause toggle pulse          (master -> slave)
//   load       1  copy preset into count, go idle     (master -> slave)
//   inc        1  preset += 1 pulse                   (master -> slave)
//   clr_preset 1  preset <= 0 pulse                   (master -> slave)
//   count      W  current countdown value, BCD pairs  (slave -> master)
//   preset     W  preset value, BCD pairs             (slave -> master)
//   running    1  timer is counting                   (slave -> master)
//   done       1  timer reached zero and stopped      (slave -> master)
//   expired    1  one-cycle pulse on reaching zero    (slave -> master)
//   tick       1  one-cycle pulse per decrement       (slave -> master)
//
// The button layer acts as master; the timer core is the slave.
interface bcd_countdown_timer_if #(
    parameter int NUM_PAIRS = 2
);
    localparam int W = 8 * NUM_PAIRS;

    logic         start;
    logic         load;
    logic         inc;
    logic         clr_preset;
    logic [W-1:0] count;
    logic [W-1:0] preset;
    logic         running;
    logic         done;
    logic         expired;
    logic         tick;

    modport master (
        output start, load, inc, clr_preset,
        input  count, preset, running, done, expired, tick
    );

    modport slave (
        input  start, load, inc, clr_preset,
        output count, preset, running, done, expired, tick
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer with NUM_PAIRS base-60 digit pairs (2 = MM:SS, 3 = HH:MM:SS).
// It holds an editable preset, loads it into the count, and counts down once per
// PRESCALE clock cycles while running. Reaching zero raises expired and stops in DONE.
//
// Optional feature macro: AUTO_RELOAD_EN
//   When defined, reaching zero while running reloads the preset and keeps running
//   (periodic mode). A zero preset still ends in DONE.
//
// Ports
//   clk    in  system clock, all logic on posedge
//   reset  in  synchronous active-low reset
//   bus    slave modport of bcd_countdown_timer_if:
//          in  start, load, inc, clr_preset (single-cycle pulses)
//          out count, preset (BCD pairs), running, done, expired, tick
//
// State table
//   state | meaning
//   IDLE  | loaded or reset, waiting for start
//   RUN   | counting down, prescaler advancing
//   PAUSE | counting suspended, prescaler phase held
//   DONE  | count reached zero, only load or reset leave
module bcd_countdown_timer #(
    parameter int NUM_PAIRS = 2,
    parameter int PRESCALE  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);
    localparam int W  = 8 * NUM_PAIRS;
    localparam int PW = $clog2(PRESCALE);

    // The prescaler is a down-counter holding the cycles left until the next tick;
    // PRESC_TOP corresponds to a freshly started tick period.
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);
    localparam logic [W-1:0]  CNT_ONE   = W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc_cnt;

    // Base-60 BCD increment; carry out of the top pair is dropped so 59..59 wraps to 0.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (carry) begin
                if (v[8*p +: 4] == 4'd9) begin
                    r[8*p +: 4] = 4'd0;
                    if (v[8*p+4 +: 4] == 4'd5) begin
                        r[8*p+4 +: 4] = 4'd0;
                    end else begin
                        r[8*p+4 +: 4] = v[8*p+4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    r[8*p +: 4] = v[8*p +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Base-60 BCD decrement; only called with a nonzero value.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (borrow) begin
                if (v[8*p +: 4] == 4'd0) begin
                    r[8*p +: 4] = 4'd9;
                    if (v[8*p+4 +: 4] == 4'd0) begin
                        r[8*p+4 +: 4] = 4'd5;
                    end else begin
                        r[8*p+4 +: 4] = v[8*p+4 +: 4] - 4'd1;
                        borrow        = 1'b0;
                    end
                end else begin
                    r[8*p +: 4] = v[8*p +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        bus.tick    <= 1'b0;
        bus.expired <= 1'b0;
        if (!reset) begin
            state       <= IDLE;
            presc_cnt   <= PRESC_TOP;
            bus.count   <= '0;
            bus.preset  <= '0;
            bus.running <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            if (bus.clr_preset) begin
                bus.preset <= '0;
            end else if (bus.inc) begin
                bus.preset <= bcd_inc(bus.preset);
            end

            if (bus.load) begin
                state       <= IDLE;
                bus.count   <= bus.preset;
                presc_cnt   <= PRESC_TOP;
                bus.running <= 1'b0;
                bus.done    <= 1'b0;
            end else if (bus.start) begin
                // A start in RUN pauses before any pending tick; presc_cnt is kept
                // so a resume finishes the partial tick period.
                case (state)
                    IDLE: begin
                        if (bus.count != '0) begin
                            state       <= RUN;
                            bus.running <= 1'b1;
                        end
                    end
                    RUN: begin
                        state       <= PAUSE;
                        bus.running <= 1'b0;
                    end
                    PAUSE: begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (state == RUN) begin
                if (presc_cnt == '0) begin
                    presc_cnt <= PRESC_TOP;
                    bus.tick  <= 1'b1;
                    if (bus.count == CNT_ONE) begin
                        bus.expired <= 1'b1;
`ifdef AUTO_RELOAD_EN
                        if (bus.preset != '0) begin
                            bus.count <= bus.preset;
                        end else begin
                            bus.count   <= '0;
                            state       <= DONE;
                            bus.running <= 1'b0;
                            bus.done    <= 1'b1;
                        end
`else
                        bus.count   <= '0;
                        state       <= DONE;
                        bus.running <= 1'b0;
                        bus.done    <= 1'b1;
`endif
                    end else begin
                        bus.count <= bcd_dec(bus.count);
                    end
                end else begin
                    presc_cnt <= presc_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (NUM_PAIRS=2, PRESCALE=4).
// A reference model tracks count/preset as plain integers of seconds and the tick
// phase as an up-counter; a compare process checks every output each cycle, and
// directed sequences pin the model with literal expectations.
module tb_bcd_countdown_timer;
    localparam int NP  = 2;
    localparam int PS  = 4;
    localparam int MOD = 60 ** NP;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic clk = 1'b0;
    logic reset;

    bcd_countdown_timer_if #(.NUM_PAIRS(NP)) bif ();

    bcd_countdown_timer #(.NUM_PAIRS(NP), .PRESCALE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int st;
        int cnt;
        int pre;
        int ph;
        bit tk;
        bit ex;
    } mstate_t;

    mstate_t m;
    bit      m_valid = 1'b0;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int p = 0; p < NP; p++) begin
            int pr;
            pr = x % 60;
            r  = r | (32'(((pr / 10) << 4) | (pr % 10)) << (8 * p));
            x  = x / 60;
        end
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input bit rst_n, input bit st,
                                           input bit ld, input bit in, input bit clr);
        mstate_t n;
        n    = s;
        n.tk = 1'b0;
        n.ex = 1'b0;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        if (clr)     n.pre = 0;
        else if (in) n.pre = (s.pre + 1) % MOD;
        if (ld) begin
            n.st  = S_IDLE;
            n.cnt = s.pre;
            n.ph  = 0;
        end else if (st) begin
            if (s.st == S_IDLE && s.cnt != 0) n.st = S_RUN;
            else if (s.st == S_RUN)           n.st = S_PAUSE;
            else if (s.st == S_PAUSE)         n.st = S_RUN;
        end else if (s.st == S_RUN) begin
            if (s.ph == PS - 1) begin
                n.ph  = 0;
                n.tk  = 1'b1;
                n.cnt = s.cnt - 1;
                if (n.cnt == 0) begin
                    n.ex = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (s.pre != 0) n.cnt = s.pre;
                    else            n.st  = S_DONE;
`else
                    n.st = S_DONE;
`endif
                end
            end else begin
                n.ph = s.ph + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_step(m, reset, bif.start, bif.load, bif.inc, bif.clr_preset);
        if (!reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_count",   32'(bif.count),   to_bcd(m.cnt));
            chk("cmp_preset",  32'(bif.preset),  to_bcd(m.pre));
            chk("cmp_running", 32'(bif.running), 32'(m.st == S_RUN));
            chk("cmp_done",    32'(bif.done),    32'(m.st == S_DONE));
            chk("cmp_expired", 32'(bif.expired), 32'(m.ex));
            chk("cmp_tick",    32'(bif.tick),    32'(m.tk));
        end
    end

    // One input cycle: drive just after a posedge, sampled at the next posedge.
    task automatic step(input bit s, input bit l, input bit i, input bit c);
        bif.start      = s;
        bif.load       = l;
        bif.inc        = i;
        bif.clr_preset = c;
        @(posedge clk);
        #1;
        bif.start      = 1'b0;
        bif.load       = 1'b0;
        bif.inc        = 1'b0;
        bif.clr_preset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until the next tick, bounded; returns 99 if none arrives.
    task automatic wait_tick(input int limit, output int n);
        bit found;
        found = 1'b0;
        n     = 99;
        for (int i = 1; i <= limit && !found; i++) begin
            @(posedge clk);
            #1;
            if (bif.tick) begin
                found = 1'b1;
                n     = i;
            end
        end
    endtask

    initial begin
        int n;
        reset          = 1'b0;
        bif.start      = 1'b0;
        bif.load       = 1'b0;
        bif.inc        = 1'b0;
        bif.clr_preset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("rst_count",   32'(bif.count),   32'h0);
        chk("rst_preset",  32'(bif.preset),  32'h0);
        chk("rst_running", 32'(bif.running), 32'h0);
        chk("rst_done",    32'(bif.done),    32'h0);

        // Preset carry chain and wrap
        repeat (60) step(0, 0, 1, 0);
        chk("inc60", 32'(bif.preset), 32'h0100);
        repeat (3540) step(0, 0, 1, 0);
        chk("inc3600_wrap", 32'(bif.preset), 32'h0000);
        repeat (5) step(0, 0, 1, 0);
        chk("inc5", 32'(bif.preset), 32'h0005);
        step(0, 0, 1, 1);
        chk("clr_over_inc", 32'(bif.preset), 32'h0000);

`ifndef AUTO_RELOAD_EN
        // Count 2 down to DONE
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("t3_load", 32'(bif.count), 32'h0002);
        step(1, 0, 0, 0);
        chk("t3_running", 32'(bif.running), 32'h1);
        wait_tick(10, n);
        chk("t3_first_tick_lat", 32'(n), 32'd4);
        chk("t3_count1", 32'(bif.count), 32'h0001);
        wait_tick(10, n);
        chk("t3_second_tick_lat", 32'(n), 32'd4);
        chk("t3_count0",   32'(bif.count),   32'h0000);
        chk("t3_expired",  32'(bif.expired), 32'h1);
        chk("t3_done",     32'(bif.done),    32'h1);
        chk("t3_running0", 32'(bif.running), 32'h0);
        idle(2);
        step(1, 0, 0, 0);
        idle(1);
        chk("t3_start_in_done", 32'(bif.done), 32'h1);
        chk("t3_count_held",    32'(bif.count), 32'h0000);
`endif

        // Pause mid-period, resume keeps the fractional tick
        step(0, 0, 0, 1);
        repeat (60) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("t4_load", 32'(bif.count), 32'h0100);
        step(1, 0, 0, 0);
        wait_tick(10, n);
        chk("t4_first_tick_lat", 32'(n), 32'd4);
        chk("t4_borrow", 32'(bif.count), 32'h0059);
        idle(2);
        step(1, 0, 0, 0);
        chk("t4_paused", 32'(bif.running), 32'h0);
        idle(20);
        chk("t4_pause_hold", 32'(bif.count), 32'h0059);
        step(1, 0, 0, 0);
        wait_tick(10, n);
        chk("t4_resume_lat", 32'(n), 32'd2);
        chk("t4_count58", 32'(bif.count), 32'h0058);

        // Start with zero count is ignored; load beats start
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        idle(1);
        chk("t5_zero_start", 32'(bif.running), 32'h0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("t5_run", 32'(bif.running), 32'h1);
        idle(2);
        step(1, 1, 0, 0);
        chk("t5_load_wins_run", 32'(bif.running), 32'h0);
        chk("t5_load_count",    32'(bif.count),   32'h0003);

        // Reset with nonzero state
        step(1, 0, 0, 0);
        idle(5);
        chk("t1_pre_count", 32'(bif.count), 32'h0002);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t1_count",   32'(bif.count),   32'h0);
        chk("t1_preset",  32'(bif.preset),  32'h0);
        chk("t1_running", 32'(bif.running), 32'h0);
        chk("t1_tick",    32'(bif.tick),    32'h0);

`ifdef AUTO_RELOAD_EN
        begin
            int prev;
            int nexp;
            prev = -1;
            nexp = 0;
            repeat (3) step(0, 0, 1, 0);
            step(0, 1, 0, 0);
            step(1, 0, 0, 0);
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                #1;
                chk("t6_running", 32'(bif.running), 32'h1);
                if (bif.expired) begin
                    nexp++;
                    chk("t6_reload", 32'(bif.count), 32'h0003);
                    if (prev >= 0) chk("t6_period", 32'(i - prev), 32'd12);
                    prev = i;
                end
            end
            chk("t6_expiries", 32'(nexp), 32'd3);
        end
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end
endmodule
